// File: rtl/gate_sweep_pkg.sv
// Shared constants and types for the gate sweeper: operand width, vector count,
// the sequencer state encoding and the bit position of each gate in fail_mask.
// No logic, so there is no latency and no backpressure.
package gate_sweep_pkg;

  localparam int OPW  = 4;            // operand width of the gate block under test
  localparam int IDXW = 2 * OPW;      // vector index covers both operands
  localparam int NVEC = 1 << IDXW;    // 256 vectors in a full sweep
  localparam int NFN  = 5;            // AND, OR, XOR, NAND, NOR

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // Bit positions inside mismatch / fail_mask
  localparam int FM_AND  = 0;
  localparam int FM_OR   = 1;
  localparam int FM_XOR  = 2;
  localparam int FM_NAND = 3;
  localparam int FM_NOR  = 4;

endpackage

// File: rtl/gate_sweep_ref.sv
// Expected-result generator and comparator for the five gate functions.
// Purely combinational (zero latency); no backpressure.
// Ports: a, b operands; y1..y5 returned AND/OR/XOR/NAND/NOR; mismatch[4:0] one bit per gate.
module gate_sweep_ref
  import gate_sweep_pkg::*;
(
  input  logic [OPW-1:0] a,
  input  logic [OPW-1:0] b,
  input  logic [OPW-1:0] y1,
  input  logic [OPW-1:0] y2,
  input  logic [OPW-1:0] y3,
  input  logic [OPW-1:0] y4,
  input  logic [OPW-1:0] y5,
  output logic [NFN-1:0] mismatch
);

  always_comb begin
    mismatch          = '0;
    mismatch[FM_AND]  = (y1 != (a & b));
    mismatch[FM_OR]   = (y2 != (a | b));
    mismatch[FM_XOR]  = (y3 != (a ^ b));
    mismatch[FM_NAND] = (y4 != ~(a & b));
    mismatch[FM_NOR]  = (y5 != ~(a | b));
  end

endmodule

// File: rtl/gate_sweeper.sv
// Exhaustive tester for a 4-bit AND/OR/XOR/NAND/NOR block: drives all 256 operand
// pairs, holds each for SETTLE cycles, then samples and compares (SETTLE+1 cycles/vector).
// No backpressure: start is ignored while busy; results hold in DONE until restart/reset.
// Ports: clk, rst (sync, active high), start; a_o/b_o to the block, y1_i..y5_i back;
// busy, done, pass, err_cnt, fail_a/fail_b/fail_mask (first failing vector).
// Build option: GATE_SWEEP_STOP_ON_FAIL_EN ends the sweep at the first failing vector.
module gate_sweeper
  import gate_sweep_pkg::*;
#(
  parameter int SETTLE = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic [OPW-1:0]  a_o,
  output logic [OPW-1:0]  b_o,
  input  logic [OPW-1:0]  y1_i,
  input  logic [OPW-1:0]  y2_i,
  input  logic [OPW-1:0]  y3_i,
  input  logic [OPW-1:0]  y4_i,
  input  logic [OPW-1:0]  y5_i,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [8:0]      err_cnt,
  output logic [OPW-1:0]  fail_a,
  output logic [OPW-1:0]  fail_b,
  output logic [NFN-1:0]  fail_mask
);

  state_t            state, state_nxt;
  logic [IDXW-1:0]   idx;
  logic [3:0]        settle_cnt;
  logic [NFN-1:0]    mismatch;
  logic              settle_last;
  logic              last_vec;
  logic              fail_now;
  logic              stop_now;

  assign a_o = idx[IDXW-1:OPW];
  assign b_o = idx[OPW-1:0];

  gate_sweep_ref u_ref (
    .a        (a_o),
    .b        (b_o),
    .y1       (y1_i),
    .y2       (y2_i),
    .y3       (y3_i),
    .y4       (y4_i),
    .y5       (y5_i),
    .mismatch (mismatch)
  );

  assign settle_last = (settle_cnt == 4'(SETTLE - 1));
  assign last_vec    = (idx == IDXW'(NVEC - 1));
  assign fail_now    = (state == ST_SAMPLE) && (mismatch != '0);

`ifdef GATE_SWEEP_STOP_ON_FAIL_EN
  assign stop_now = fail_now;
`else
  assign stop_now = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_DONE: if (start)       state_nxt = ST_DRIVE;
      ST_DRIVE:         if (settle_last) state_nxt = ST_SAMPLE;
      ST_SAMPLE:        state_nxt = (last_vec || stop_now) ? ST_DONE : ST_DRIVE;
      default:          state_nxt = ST_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    busy = (state == ST_DRIVE) || (state == ST_SAMPLE);
    done = (state == ST_DONE);
    pass = (state == ST_DONE) && (err_cnt == '0);
  end

  // Sweep datapath: vector index, settle timer and result capture
  always_ff @(posedge clk) begin
    if (rst) begin
      idx        <= '0;
      settle_cnt <= '0;
      err_cnt    <= '0;
      fail_a     <= '0;
      fail_b     <= '0;
      fail_mask  <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            idx        <= '0;
            settle_cnt <= '0;
            err_cnt    <= '0;
            fail_a     <= '0;
            fail_b     <= '0;
            fail_mask  <= '0;
          end
        end
        ST_DRIVE: begin
          settle_cnt <= settle_last ? 4'd0 : settle_cnt + 4'd1;
        end
        ST_SAMPLE: begin
          if (fail_now) begin
            if (err_cnt != 9'(NVEC)) err_cnt <= err_cnt + 9'd1;
            // err_cnt still zero means this is the first failing vector
            if (err_cnt == '0) begin
              fail_a    <= a_o;
              fail_b    <= b_o;
              fail_mask <= mismatch;
            end
          end
          // On a stop the index is held so a_o/b_o keep showing the culprit
          if (!(last_vec || stop_now)) idx <= idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_sweeper.sv
module tb_gate_sweeper;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start1 = 1'b0;
  logic       start3 = 1'b0;

  logic [3:0] a1, b1, a3, b3;
  logic [3:0] y1_1, y2_1, y3_1, y4_1, y5_1;
  logic [3:0] y1_3, y2_3, y3_3, y4_3, y5_3;
  logic       busy1, done1, pass1, busy3, done3, pass3;
  logic [8:0] err1, err3;
  logic [3:0] fa1, fb1, fa3, fb3;
  logic [4:0] fm1, fm3;

  int checks = 0;
  int errors = 0;

  // 0 = correct gates, 1 = OR output returns XOR, 2 = random bit flips from inj[]
  int          mode = 0;
  logic [19:0] inj [256];

  always #5 clk = ~clk;

  gate_sweeper #(.SETTLE(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a_o(a1), .b_o(b1),
    .y1_i(y1_1), .y2_i(y2_1), .y3_i(y3_1), .y4_i(y4_1), .y5_i(y5_1),
    .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1),
    .fail_a(fa1), .fail_b(fb1), .fail_mask(fm1)
  );

  gate_sweeper #(.SETTLE(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .a_o(a3), .b_o(b3),
    .y1_i(y1_3), .y2_i(y2_3), .y3_i(y3_3), .y4_i(y4_3), .y5_i(y5_3),
    .busy(busy3), .done(done3), .pass(pass3), .err_cnt(err3),
    .fail_a(fa3), .fail_b(fb3), .fail_mask(fm3)
  );

  // Ideal gate k (0=AND .. 4=NOR)
  function automatic logic [3:0] gold(input int k, input logic [3:0] a, input logic [3:0] b);
    case (k)
      0:       return a & b;
      1:       return a | b;
      2:       return a ^ b;
      3:       return ~(a & b);
      default: return ~(a | b);
    endcase
  endfunction

  // Behaviour of the (possibly broken) gate block looped back to the DUT
  function automatic logic [3:0] loop_y(input int k, input logic [3:0] a, input logic [3:0] b);
    logic [19:0] f;
    if (mode == 1 && k == 1) return a ^ b;
    if (mode == 2) begin
      f = inj[{a, b}];
      return gold(k, a, b) ^ f[4*k +: 4];
    end
    return gold(k, a, b);
  endfunction

  always_comb begin
    y1_1 = loop_y(0, a1, b1); y2_1 = loop_y(1, a1, b1); y3_1 = loop_y(2, a1, b1);
    y4_1 = loop_y(3, a1, b1); y5_1 = loop_y(4, a1, b1);
    y1_3 = loop_y(0, a3, b3); y2_3 = loop_y(1, a3, b3); y3_3 = loop_y(2, a3, b3);
    y4_3 = loop_y(3, a3, b3); y5_3 = loop_y(4, a3, b3);
  end

  // Reference: walk all vectors and derive count, first failure and its mask
  task automatic model(output int exp_err, output int first_idx, output logic [4:0] first_mask);
    logic [4:0] mm;
    logic [3:0] a, b;
    exp_err = 0; first_idx = -1; first_mask = '0;
    for (int v = 0; v < 256; v++) begin
      a = 4'(v >> 4); b = 4'(v & 15);
      mm = '0;
      for (int k = 0; k < 5; k++) mm[k] = (loop_y(k, a, b) != gold(k, a, b));
      if (mm != 0) begin
        if (first_idx < 0) begin first_idx = v; first_mask = mm; end
        exp_err++;
      end
    end
  endtask

  // Run a sweep on dut1; optional start re-pulse at cycle restart_at.
  // n_done = cycles from the start edge until done is seen; idx_bad counts
  // cycles where a_o/b_o or busy disagreed with the expected sweep position.
  task automatic sweep1(input int restart_at, output int n_done, output int idx_bad);
    int n;
    idx_bad = 0;
    @(negedge clk); start1 = 1'b1;
    @(negedge clk); start1 = 1'b0; n = 0;
    while (done1 !== 1'b1 && n < 3000) begin
      if (busy1 !== 1'b1 || {a1, b1} !== 8'(n / 2)) idx_bad++;
      start1 = (n == restart_at);
      @(negedge clk); n++;
    end
    start1 = 1'b0;
    n_done = n;
    checks++;
    if (n >= 3000) begin errors++; $display("FAIL sweep1_timeout: cycles=%0d limit=3000", n); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy1, done1, pass1, err1, a1, b1, fa1, fb1, fm1} !== '0) begin
      errors++;
      $display("FAIL reset_dut1: busy=%b done=%b pass=%b err=%0d a=%h b=%h fa=%h fb=%h fm=%b expected all 0",
               busy1, done1, pass1, err1, a1, b1, fa1, fb1, fm1);
    end
    checks++;
    if ({busy3, done3, pass3, err3, a3, b3, fa3, fb3, fm3} !== '0) begin
      errors++;
      $display("FAIL reset_dut3: busy=%b done=%b pass=%b err=%0d expected all 0", busy3, done3, pass3, err3);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_clean_sweep();
    int n, bad;
    mode = 0;
    sweep1(-1, n, bad);
    checks++; if (n != 512) begin errors++; $display("FAIL clean_cycles: got %0d expected 512", n); end
    checks++; if (bad != 0) begin errors++; $display("FAIL clean_idx_busy: %0d bad cycles expected 0", bad); end
    checks++;
    if (done1 !== 1 || pass1 !== 1 || err1 !== 0 || busy1 !== 0) begin
      errors++;
      $display("FAIL clean_result: done=%b pass=%b err=%0d busy=%b expected 1 1 0 0", done1, pass1, err1, busy1);
    end
    // results hold in DONE
    repeat (10) @(negedge clk);
    checks++;
    if (done1 !== 1 || pass1 !== 1 || err1 !== 0) begin
      errors++;
      $display("FAIL clean_hold: done=%b pass=%b err=%0d expected 1 1 0", done1, pass1, err1);
    end
  endtask

  task automatic test_or_fault();
    int n, bad;
    mode = 1;
    sweep1(-1, n, bad);
`ifdef GATE_SWEEP_STOP_ON_FAIL_EN
    checks++; if (n != 36) begin errors++; $display("FAIL orfault_stop_cycles: got %0d expected 36", n); end
    checks++;
    if (err1 !== 1 || a1 !== 1 || b1 !== 1) begin
      errors++; $display("FAIL orfault_stop_vec: err=%0d a=%h b=%h expected 1 1 1", err1, a1, b1);
    end
`else
    checks++; if (n != 512) begin errors++; $display("FAIL orfault_cycles: got %0d expected 512", n); end
    checks++; if (err1 !== 175) begin errors++; $display("FAIL orfault_err: got %0d expected 175", err1); end
`endif
    checks++; if (bad != 0) begin errors++; $display("FAIL orfault_idx: %0d bad cycles expected 0", bad); end
    checks++;
    if (fa1 !== 1 || fb1 !== 1 || fm1 !== 5'b00010 || pass1 !== 0 || done1 !== 1) begin
      errors++;
      $display("FAIL orfault_first: fa=%h fb=%h fm=%b pass=%b done=%b expected 1 1 00010 0 1",
               fa1, fb1, fm1, pass1, done1);
    end
    mode = 0;
  endtask

  task automatic test_random_fault();
    int n, bad, e_err, e_first, nf, v;
    logic [4:0] e_mask;
    logic [19:0] f;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 256; i++) inj[i] = '0;
      nf = $urandom_range(1, 12);
      for (int i = 0; i < nf; i++) begin
        v = $urandom_range(0, 255);
        f = 20'($urandom);
        if (f == 0) f = 20'h1;
        inj[v] = f;
      end
      mode = 2;
      model(e_err, e_first, e_mask);
      sweep1(-1, n, bad);
`ifdef GATE_SWEEP_STOP_ON_FAIL_EN
      checks++;
      if (n != (e_first + 1) * 2 || err1 !== 1 || {a1, b1} !== 8'(e_first)) begin
        errors++;
        $display("FAIL rand_stop: cycles=%0d err=%0d idx=%h expected %0d 1 %h",
                 n, err1, {a1, b1}, (e_first + 1) * 2, 8'(e_first));
      end
`else
      checks++;
      if (n != 512 || err1 !== 9'(e_err)) begin
        errors++;
        $display("FAIL rand_count: cycles=%0d err=%0d expected 512 %0d", n, err1, e_err);
      end
`endif
      checks++;
      if ({fa1, fb1} !== 8'(e_first) || fm1 !== e_mask || pass1 !== 0 || bad != 0) begin
        errors++;
        $display("FAIL rand_first: fail_ab=%h fm=%b pass=%b bad=%0d expected %h %b 0 0",
                 {fa1, fb1}, fm1, pass1, bad, 8'(e_first), e_mask);
      end
    end
    mode = 0;
  endtask

  task automatic test_reset_mid();
    int n, bad;
    mode = 1;
    @(negedge clk); start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
    repeat (100) @(negedge clk);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    checks++;
    if (busy1 !== 0 || a1 !== 0 || b1 !== 0 || err1 !== 0 || done1 !== 0 || fm1 !== 0) begin
      errors++;
      $display("FAIL rst_mid: busy=%b a=%h b=%h err=%0d done=%b fm=%b expected all 0",
               busy1, a1, b1, err1, done1, fm1);
    end
    mode = 0;
    sweep1(-1, n, bad);
    checks++;
    if (n != 512 || bad != 0 || pass1 !== 1) begin
      errors++; $display("FAIL rst_mid_resweep: cycles=%0d bad=%0d pass=%b expected 512 0 1", n, bad, pass1);
    end
  endtask

  task automatic test_restart_busy();
    int n, bad;
    mode = 0;
    sweep1(50, n, bad);
    checks++;
    if (n != 512 || bad != 0 || pass1 !== 1) begin
      errors++; $display("FAIL restart_busy: cycles=%0d bad=%0d pass=%b expected 512 0 1", n, bad, pass1);
    end
  endtask

  task automatic test_rst_priority();
    @(negedge clk); rst = 1'b1; start1 = 1'b1;
    @(negedge clk); rst = 1'b0; start1 = 1'b0;
    checks++;
    if (busy1 !== 0 || done1 !== 0 || pass1 !== 0) begin
      errors++; $display("FAIL rst_priority: busy=%b done=%b pass=%b expected 0 0 0", busy1, done1, pass1);
    end
  endtask

  task automatic test_settle3();
    int n, bad;
    mode = 0; bad = 0;
    @(negedge clk); start3 = 1'b1;
    @(negedge clk); start3 = 1'b0; n = 0;
    while (done3 !== 1'b1 && n < 5000) begin
      if (busy3 !== 1'b1 || {a3, b3} !== 8'(n / 4)) bad++;
      @(negedge clk); n++;
    end
    checks++; if (n != 1024) begin errors++; $display("FAIL settle3_cycles: got %0d expected 1024", n); end
    checks++; if (bad != 0) begin errors++; $display("FAIL settle3_idx: %0d bad cycles expected 0", bad); end
    checks++;
    if (pass3 !== 1 || err3 !== 0) begin
      errors++; $display("FAIL settle3_result: pass=%b err=%0d expected 1 0", pass3, err3);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) inj[i] = '0;
    test_reset();
    test_clean_sweep();
    test_or_fault();
    test_random_fault();
    test_reset_mid();
    test_restart_busy();
    test_rst_priority();
    test_settle3();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gate_sweeper.md
GATE_SWEEPER -- requirements
Module: gate_sweeper

Interface
REQ-001 SHALL have parameter SETTLE, default 1, range 1..15: cycles each vector is driven before its outputs are sampled.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port start, input, 1 bit: begins a sweep when sampled high in IDLE or DONE.
REQ-005 SHALL have ports a_o and b_o, output, 4 bits each: operand buses driven to the gate block under test.
REQ-006 SHALL have ports y1_i..y5_i, input, 4 bits each: returned AND, OR, XOR, NAND and NOR results.
REQ-007 SHALL have port busy, output, 1 bit: high in DRIVE and SAMPLE.
REQ-008 SHALL have port done, output, 1 bit: high in DONE.
REQ-009 SHALL have port pass, output, 1 bit: high in DONE when err_cnt is 0.
REQ-010 SHALL have port err_cnt, output, 9 bits: count of vectors with any mismatch.
REQ-011 SHALL have ports fail_a and fail_b (4 bits each) and fail_mask (5 bits, bit0 = y1 .. bit4 = y5): first failing vector and the outputs that failed on it.

Function
REQ-012 SHALL run an FSM with states IDLE, DRIVE, SAMPLE and DONE.
REQ-013 SHALL map the 8-bit vector index idx as a_o = idx[7:4] and b_o = idx[3:0], held stable throughout DRIVE and SAMPLE.
REQ-014 SHALL, on start in IDLE or DONE: set idx = 0, clear err_cnt, fail_a, fail_b and fail_mask, and enter DRIVE.
REQ-015 SHALL remain in DRIVE for exactly SETTLE cycles, then enter SAMPLE.
REQ-016 SHALL, in SAMPLE, compare y1_i..y5_i against a&b, a|b, a^b, ~(a&b) and ~(a|b) (bitwise, 4 bits), forming a 5-bit mismatch vector.
REQ-017 SHALL, when the mismatch vector is nonzero: increment err_cnt (saturating at 256); if this is the first failure, capture fail_a, fail_b and fail_mask.
REQ-018 SHALL, on leaving SAMPLE: if idx = 255, enter DONE; otherwise increment idx and return to DRIVE.
REQ-019 SHALL complete a full sweep in 256 x (SETTLE + 1) cycles from the start edge.
REQ-020 SHALL ignore start while busy.
REQ-021 SHALL hold done, pass, err_cnt and the fail_* outputs in DONE until a restart or reset.
REQ-022 SHALL keep pass low outside DONE.

Reset
REQ-023 SHALL, on rst high at any clock edge, including mid-sweep, force IDLE and set a_o, b_o, busy, done, pass, err_cnt, fail_a, fail_b, fail_mask and idx to 0.
REQ-024 SHALL give rst priority over start when both are high in the same cycle.

Configuration
REQ-025 SHALL, with GATE_SWEEP_STOP_ON_FAIL_EN defined, enter DONE directly from the SAMPLE cycle of the first failing vector, with err_cnt = 1 and a_o/b_o holding that vector.
REQ-026 SHALL, without GATE_SWEEP_STOP_ON_FAIL_EN, always sweep all 256 vectors and count every failing vector.

Structure
REQ-027 SHALL place in package gate_sweep_pkg: the operand width constant (4), the vector count (256), the state enum, and the fail_mask bit positions.
REQ-028 SHALL implement the five-function expected-result and compare logic as one sub-module, gate_sweep_ref, with inputs a, b and y1..y5 and output mismatch[4:0].

Verification
REQ-029 SHALL cover: correct AND/OR/XOR/NAND/NOR model looped back, SETTLE=1, start pulse -> busy for 512 cycles, then done=1, pass=1, err_cnt=0.
REQ-030 SHALL cover: model with y2 returning a^b instead of a|b -> err_cnt=175, fail_a=1, fail_b=1, fail_mask=5'b00010, pass=0.
REQ-031 SHALL cover: same faulty model with GATE_SWEEP_STOP_ON_FAIL_EN -> done after sampling idx 0x11, err_cnt=1, a_o=1, b_o=1.
REQ-032 SHALL cover: rst pulsed at cycle 100 of a sweep -> next cycle busy=0, a_o=0, b_o=0, err_cnt=0; a new start sweeps from idx 0.
REQ-033 SHALL cover: start re-pulsed at cycle 50 while busy -> sweep unaffected, done still asserts at cycle 512.
REQ-034 SHALL cover: SETTLE=3 with the correct model -> done asserts after 1024 cycles, with a_o/b_o changing only every 4 cycles.
